// File: rtl/ro_sampler.sv
// ro_sampler: seeds a ring-oscillator loop, samples it, debiases with von Neumann and delivers packed words over syn/ack
module ro_sampler #(
  parameter int SEED_CYCLES = 16,
  parameter int SAMPLE_DIV  = 8,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  ro_d,
  output logic                  ro_ctrl,
  output logic                  ro_seed,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  syn,
  input  logic                  ack
);
  localparam logic [1:0] IDLE = 2'd0, SEED = 2'd1, RUN = 2'd2;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [7:0] SEED_LOAD = 8'(SEED_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  logic [1:0] state;
  logic [7:0] seed_cnt, div;
  logic [1:0] sync;
  logic ro_sync, pair_full, first, strobe, emit, word_done;
  logic [DATA_WIDTH-1:0] acc, acc_next;
  logic [CW-1:0] cnt;
  assign ro_sync = sync[1];
  assign ro_ctrl = state != RUN;
  assign strobe = state == RUN && enable && div == DIV_LAST;
  // a differing pair emits its first bit (10 -> 1, 01 -> 0)
  assign emit = strobe && pair_full && first != ro_sync;
  assign acc_next = {acc[DATA_WIDTH-2:0], first};
  assign word_done = emit && cnt == CNT_LAST;
  // two-flop synchroniser for the asynchronous oscillator output
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= '0;
    else sync <= {sync[0], ro_d};
  // seed/run control and sample divider
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      seed_cnt <= '0;
      div <= '0;
      ro_seed <= 1'b0;
    end else if (state == IDLE) begin
      if (enable) begin
        state <= SEED;
        ro_seed <= ~ro_seed;
        seed_cnt <= SEED_LOAD;
      end
    end else if (!enable) state <= IDLE;
    else if (state == SEED) begin
      if (seed_cnt == '0) begin
        state <= RUN;
        div <= '0;
      end else seed_cnt <= seed_cnt - 1'b1;
    end else if (state == RUN) div <= div == DIV_LAST ? '0 : div + 1'b1;
    else state <= IDLE;
  // pair tracking and bit accumulation; leaving a run discards partial work
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pair_full <= 1'b0;
      first <= 1'b0;
      acc <= '0;
      cnt <= '0;
    end else if (state != IDLE && !enable) begin
      pair_full <= 1'b0;
      acc <= '0;
      cnt <= '0;
    end else if (strobe) begin
      pair_full <= ~pair_full;
      if (!pair_full) first <= ro_sync;
      if (emit) begin
        acc <= acc_next;
        cnt <= word_done ? '0 : cnt + 1'b1;
      end
    end
  // word delivery: a word finishing while an unacked one is pending is dropped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data <= '0;
      syn <= 1'b0;
    end else if (word_done && (!syn || ack)) begin
      data <= acc_next;
      syn <= 1'b1;
    end else if (ack) syn <= 1'b0;
endmodule

// File: tb/tb_ro_sampler.sv
// tb_ro_sampler: directed stimulus with a behavioural reference model and literal checkpoints
module tb_ro_sampler;
  localparam int SC = 4, SD = 8, DW = 8;
  logic clk = 0, reset_n = 0, enable = 1, ro_d = 0, ack = 0;
  logic ro_ctrl, ro_seed, syn;
  logic [DW-1:0] data;
  int n_chk = 0, n_fail = 0;
  int runcyc = -1, n, seeds;
  logic q[$];
  logic s_rst = 0, s_en = 0, s_ack = 0, s_rd = 0;
  int m_ph = 0, m_left = 0, m_run = 0, m_first = -1;
  logic m_seed = 0, m_syn = 0, h1 = 0, h2 = 0, samp;
  logic [DW-1:0] m_data = '0;
  logic mq[$];

  ro_sampler #(.SEED_CYCLES(SC), .SAMPLE_DIV(SD), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ro_d(ro_d),
    .ro_ctrl(ro_ctrl), .ro_seed(ro_seed), .data(data), .syn(syn), .ack(ack)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; in RUN a new sample is driven right after each strobe so it is settled through the synchroniser by the next one
  task automatic tick;
    @(negedge clk);
    if (ro_ctrl) runcyc = -1;
    else begin
      runcyc++;
      if (runcyc % SD == 0) ro_d = q.size() != 0 ? q.pop_front() : 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic wait_syn(input string name);
    int k = 0;
    while (!syn && k < 2000) begin tick; k++; end
    check(name, syn, 1);
  endtask

  task automatic wait_rc(input int target);
    int k = 0;
    while (runcyc != target && k < 2000) begin tick; k++; end
    check("runcyc_reach", runcyc, target);
  endtask

  always @(posedge clk) begin
    s_rst <= reset_n;
    s_en <= enable;
    s_ack <= ack;
    s_rd <= ro_d;
  end

  // Reference model stepped once per clock from the inputs seen at the edge, then compared with the DUT
  initial forever begin
    @(negedge clk);
    if (!s_rst || !reset_n) begin
      m_ph = 0; m_left = 0; m_run = 0; m_first = -1;
      m_seed = 0; m_syn = 0; m_data = '0; h1 = 0; h2 = 0;
      mq.delete();
    end else begin
      samp = h2; h2 = h1; h1 = s_rd;
      if (m_syn && s_ack) m_syn = 0;
      if (m_ph == 0) begin
        if (s_en) begin m_ph = 1; m_seed = !m_seed; m_left = SC; end
      end else if (!s_en) begin
        m_ph = 0; m_first = -1; mq.delete();
      end else if (m_ph == 1) begin
        m_left--;
        if (m_left == 0) begin m_ph = 2; m_run = 0; end
      end else begin
        m_run++;
        if (m_run % SD == 0) begin
          if (m_first < 0) m_first = int'(samp);
          else begin
            if (m_first != int'(samp)) mq.push_back(m_first == 1);
            m_first = -1;
          end
          if (mq.size() == DW) begin
            if (!m_syn) begin
              m_data = '0;
              foreach (mq[i]) m_data = {m_data[DW-2:0], mq[i]};
              m_syn = 1;
            end
            mq.delete();
          end
        end
      end
    end
    if (reset_n) begin
      check("m_ro_ctrl", ro_ctrl, m_ph != 2);
      check("m_ro_seed", ro_seed, m_seed);
      check("m_syn", syn, m_syn);
      check("m_data", data, m_data);
    end
  end

  initial begin
    #1;
    check("rst_ro_ctrl", ro_ctrl, 1);
    check("rst_ro_seed", ro_seed, 0);
    check("rst_syn", syn, 0);
    check("rst_data", data, 0);
    push(16'b10_01_10_10_01_01_10_01, 16);
    push(24'b10_00_01_11_10_00_10_11_01_01_10_01, 24);
    push(16'b01_01_01_01_01_01_01_01, 16);
    push(16'b10_10_10_10_10_10_10_10, 16);
    push(10'b10_01_10_01_10, 10);
    repeat (2) tick;
    reset_n = 1;
    n = 0; seeds = 0;
    while (n < 50) begin
      tick; n++;
      if (!ro_ctrl) break;
      if (ro_seed) seeds++;
    end
    check("seed_len", seeds, SC);
    check("run_ctrl", ro_ctrl, 0);
    wait_syn("word1_syn");
    check("word1_data", data, 8'b10110010);
    check("word1_latency", runcyc, SD * 16);
    ack = 1;
    tick;
    ack = 0;
    check("word1_ack", syn, 0);
    wait_syn("word2_syn");
    check("word2_data", data, 8'b10110010);
    check("word2_latency", runcyc, SD * 40);
    wait_rc(SD * 56);
    check("word3_syn_held", syn, 1);
    check("word3_data_kept", data, 8'b10110010);
    ack = 1;
    tick;
    ack = 0;
    check("word3_ack", syn, 0);
    wait_syn("word4_syn");
    check("word4_data", data, 8'hFF);
    wait_rc(SD * 82 + 4);
    enable = 0;
    q.delete();
    repeat (3) tick;
    check("drop_ctrl", ro_ctrl, 1);
    check("drop_syn_kept", syn, 1);
    check("drop_data_kept", data, 8'hFF);
    enable = 1;
    push(16'b01_10_01_10_01_10_01_10, 16);
    tick;
    check("reseed_ctrl", ro_ctrl, 1);
    check("reseed_value", ro_seed, 0);
    ack = 1;
    tick;
    ack = 0;
    check("word4_ack", syn, 0);
    wait_syn("word5_syn");
    check("word5_data", data, 8'h55);
    check("word5_latency", runcyc, SD * 16);
    #3 reset_n = 0;
    #1;
    check("arst_syn", syn, 0);
    check("arst_data", data, 0);
    check("arst_ro_ctrl", ro_ctrl, 1);
    check("arst_ro_seed", ro_seed, 0);
    enable = 0;
    repeat (2) tick;
    reset_n = 1;
    repeat (3) tick;
    check("idle_after_rst", ro_ctrl, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
